// File: rtl/skew_buf_pkg.sv
// Shared types and width helpers for the skewed ping-pong operand buffer.
//   state_t : streaming FSM states
//   steps() : number of skew steps that one DIM x DIM stream occupies
//   row_w() / step_w() : index widths for matrix rows and skew steps
package skew_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  function automatic int steps(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int row_w(input int dim);
    return $clog2(dim);
  endfunction

  function automatic int step_w(input int dim);
    return $clog2(2 * dim - 1);
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One DIM x DIM operand bank: a full-row write port and a combinational,
// diagonally skewed read at step i_step.
//   clk     : clock
//   i_we    : write i_data into row i_row
//   i_row   : row index
//   i_data  : row elements, element c = column c
//   i_step  : skew step t
//   o_lanes : lane j = element on the t-j diagonal (row or column j), else 0
module skew_bank
  import skew_buf_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int DIM      = 8,
  parameter int COL_MODE = 0
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [row_w(DIM)-1:0]          i_row,
  input  logic [DIM-1:0][BITS-1:0]       i_data,
  input  logic [step_w(DIM)-1:0]         i_step,
  output logic [DIM-1:0][BITS-1:0]       o_lanes
);

  localparam int SW = step_w(DIM);
  localparam int RW = row_w(DIM);
  localparam int DIM_I = DIM;
  localparam logic signed [SW:0] DIM_S = DIM_I[SW:0];

  // Storage is intentionally not reset; the full flags gate its use.
  logic [DIM-1:0][BITS-1:0] r_mem [DIM];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_row] <= i_data;
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    localparam int J_I = j;
    localparam logic signed [SW:0] J_S = J_I[SW:0];

    // t-j is evaluated one bit wider than t so that t<j is seen as negative.
    logic signed [SW:0] w_k;
    logic [RW-1:0]      w_idx;

    assign w_k   = $signed({1'b0, i_step}) - J_S;
    assign w_idx = w_k[RW-1:0];

    assign o_lanes[j] = (!w_k[SW] && (w_k < DIM_S)) ?
                        ((COL_MODE != 0) ? r_mem[w_idx][j] : r_mem[j][w_idx]) :
                        '0;
  end

endmodule

// File: rtl/skew_pingpong_buf.sv
// Double-buffered operand memory feeding one edge of a systolic MAC array.
// The host fills the free bank row by row and commits it; the array side
// streams the committed bank with lane j delayed j cycles and zero fill.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/wr_row/wr_data : row write into the current write bank
//   wr_commit         : mark write bank full and swap write pointer
//   load_ready        : write bank is free
//   start, en         : request a stream / advance (0 = stall)
//   out_valid/out_data/out_step : live skew step, lane values, step index
//   busy, done        : streaming, one-cycle end pulse
//   banks_full        : per-bank full flags
module skew_pingpong_buf
  import skew_buf_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int DIM      = 8,
  parameter int COL_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(DIM)-1:0]        wr_row,
  input  logic [DIM-1:0][BITS-1:0]      wr_data,
  input  logic                          wr_commit,
  output logic                          load_ready,
  input  logic                          start,
  input  logic                          en,
  output logic                          out_valid,
  output logic [DIM-1:0][BITS-1:0]      out_data,
  output logic [$clog2(2*DIM-1)-1:0]    out_step,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    banks_full
);

  localparam int SW = step_w(DIM);
  localparam logic [SW-1:0] T_LAST = SW'(steps(DIM) - 1);

  state_t          r_state;
  logic [SW-1:0]   r_t;
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [1:0]      r_full;

  logic            w_wr_fire;
  logic            w_commit_fire;
  logic            w_stream_end;
  logic [1:0]      w_full_nxt;
  logic [DIM-1:0][BITS-1:0] w_lanes0;
  logic [DIM-1:0][BITS-1:0] w_lanes1;

  // Load side: both write and commit are gated by the pre-edge flags, so a
  // bank freed this cycle cannot also be committed this cycle.
  assign load_ready    = !r_full[r_wr_sel];
  assign w_wr_fire     = wr_en && load_ready;
  assign w_commit_fire = wr_commit && load_ready;
  assign w_stream_end  = (r_state == STREAM) && en && (r_t == T_LAST);

  always_comb begin
    w_full_nxt = r_full;
    if (w_commit_fire) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_stream_end)  w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_t      <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_full   <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_commit_fire) r_wr_sel <= ~r_wr_sel;
      case (r_state)
        IDLE: begin
          if (start && r_full[r_rd_sel]) begin
            r_state <= STREAM;
            r_t     <= '0;
          end
        end
        STREAM: begin
          if (en) begin
            if (r_t == T_LAST) begin
              r_state  <= DONE;
              r_rd_sel <= ~r_rd_sel;
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  skew_bank #(.BITS(BITS), .DIM(DIM), .COL_MODE(COL_MODE)) u_bank0 (
    .clk     (clk),
    .i_we    (w_wr_fire && !r_wr_sel),
    .i_row   (wr_row),
    .i_data  (wr_data),
    .i_step  (r_t),
    .o_lanes (w_lanes0)
  );

  skew_bank #(.BITS(BITS), .DIM(DIM), .COL_MODE(COL_MODE)) u_bank1 (
    .clk     (clk),
    .i_we    (w_wr_fire && r_wr_sel),
    .i_row   (wr_row),
    .i_data  (wr_data),
    .i_step  (r_t),
    .o_lanes (w_lanes1)
  );

  assign busy       = (r_state == STREAM);
  assign done       = (r_state == DONE);
  assign out_valid  = busy && en;
  assign out_step   = r_t;
  assign banks_full = r_full;
  assign out_data   = busy ? (r_rd_sel ? w_lanes1 : w_lanes0) : '0;

endmodule

// File: tb/tb_skew_pingpong_buf.sv
module tb_skew_pingpong_buf;

  localparam int BITS = 8;
  localparam int DIM  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_row = '0;
  logic [3:0][7:0]  wr_data = '0;
  logic             wr_commit = 1'b0;
  logic             start = 1'b0;
  logic             en = 1'b0;

  logic r_ready, r_valid, r_busy, r_done, c_ready, c_valid, c_busy, c_done;
  logic [3:0][7:0] r_data, c_data;
  logic [2:0] r_step, c_step;
  logic [1:0] r_full, c_full;

  skew_pingpong_buf #(.BITS(BITS), .DIM(DIM), .COL_MODE(0)) u_row (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .load_ready(r_ready), .start(start), .en(en),
    .out_valid(r_valid), .out_data(r_data), .out_step(r_step), .busy(r_busy),
    .done(r_done), .banks_full(r_full));

  skew_pingpong_buf #(.BITS(BITS), .DIM(DIM), .COL_MODE(1)) u_col (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .wr_commit(wr_commit), .load_ready(c_ready), .start(start), .en(en),
    .out_valid(c_valid), .out_data(c_data), .out_step(c_step), .busy(c_busy),
    .done(c_done), .banks_full(c_full));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two matrices, full flags, pointers, and a stream in
  // progress described by its current step.
  logic signed [7:0] m_bank [2][4][4];
  logic [1:0] m_full;
  int  m_wr, m_rd, m_t;
  bit  m_stream, m_done;

  function automatic void model_update();
    bit lr;
    bit ndone;
    int freed;
    freed = -1;
    ndone = 1'b0;
    if (rst) begin
      m_full = '0; m_wr = 0; m_rd = 0; m_t = 0; m_stream = 0; m_done = 0;
      return;
    end
    lr = !m_full[m_wr];
    if (wr_en && lr)
      for (int c = 0; c < DIM; c++) m_bank[m_wr][int'(wr_row)][c] = wr_data[c];
    if (m_stream) begin
      if (en) begin
        if (m_t == 2 * DIM - 2) begin
          freed = m_rd; m_rd = 1 - m_rd; m_stream = 0; ndone = 1;
        end else m_t = m_t + 1;
      end
    end else if (!m_done && start && m_full[m_rd]) begin
      m_stream = 1; m_t = 0;
    end
    m_done = ndone;
    if (wr_commit && lr) begin m_full[m_wr] = 1'b1; m_wr = 1 - m_wr; end
    if (freed >= 0) m_full[freed] = 1'b0;
  endfunction

  // {load_ready, out_valid, busy, done, banks_full, step (while busy), lanes}
  function automatic logic [40:0] exp_obs(input int mode);
    logic [31:0] d;
    logic [2:0]  s;
    int k;
    d = '0;
    if (m_stream)
      for (int j = 0; j < DIM; j++) begin
        k = m_t - j;
        if (k >= 0 && k < DIM)
          d[j*8 +: 8] = (mode != 0) ? m_bank[m_rd][k][j] : m_bank[m_rd][j][k];
      end
    s = m_stream ? 3'(m_t) : 3'd0;
    return {!m_full[m_wr], m_stream && en, m_stream, m_done, m_full, s, d};
  endfunction

  function automatic logic [40:0] act_obs(input int mode);
    if (mode == 0)
      return {r_ready, r_valid, r_busy, r_done, r_full, (r_busy ? r_step : 3'd0), r_data};
    return {c_ready, c_valid, c_busy, c_done, c_full, (c_busy ? c_step : 3'd0), c_data};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_bank(input bit use_a);
    for (int r = 0; r < DIM; r++) begin
      wr_en = 1'b1;
      wr_row = 2'(r);
      for (int c = 0; c < DIM; c++) wr_data[c] = use_a ? 8'(10 * r + c) : 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_vec++;
      if (act_obs(m) !== exp_obs(m)) begin
        n_err++; $display("FAIL reset mode%0d got=%h want=%h", m, act_obs(m), exp_obs(m));
      end
    end
    n_vec++;
    if (r_step !== 3'd0 || c_step !== 3'd0 || r_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_step got=%0d/%0d busy=%b want=0/0 busy=0", r_step, c_step, r_busy);
    end
  endtask

  task automatic test_single_stream();
    int dones;
    dones = 0;
    en = 1'b1;
    load_bank(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL single_stream mode%0d t=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      if (i == 0 || i == 3 || i == 6) begin
        n_vec++;
        if (r_data !== ((i == 0) ? 32'h0 : (i == 3) ? 32'h1E150C03 : 32'h21000000)) begin
          n_err++; $display("FAIL row_literal t=%0d got=%h", i, r_data);
        end
      end
      if (i == 3 || i == 5) begin
        n_vec++;
        if (c_data !== ((i == 3) ? 32'h030C151E : 32'h17200000)) begin
          n_err++; $display("FAIL col_literal t=%0d got=%h", i, c_data);
        end
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      if (r_done === 1'b1) dones++;
      if (i == 0) begin
        n_vec++;
        if (r_full !== 2'b00 || r_busy !== 1'b0 || r_data !== 32'h0) begin
          n_err++; $display("FAIL single_end full=%b busy=%b data=%h want full=00 busy=0 data=0", r_full, r_busy, r_data);
        end
      end
      step();
    end
    n_vec++;
    if (dones != 1) begin
      n_err++; $display("FAIL done_pulses got=%0d want=1", dones);
    end
  endtask

  task automatic test_pingpong();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    load_bank(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_en = (i < 4);
      wr_row = 2'(i);
      for (int c = 0; c < DIM; c++) wr_data[c] = 8'($urandom);
      wr_commit = (i == 4);
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL pingpong_a mode%0d t=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      if (i == 5) begin
        n_vec++;
        if (r_ready !== 1'b0 || r_full !== 2'b11) begin
          n_err++; $display("FAIL pp_both_full ready=%b full=%b want ready=0 full=11", r_ready, r_full);
        end
      end
      step();
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    n_vec++;
    if (r_done !== 1'b1 || r_ready !== 1'b1 || r_full !== 2'b10) begin
      n_err++; $display("FAIL pp_after_done done=%b ready=%b full=%b want 1 1 10", r_done, r_ready, r_full);
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL pingpong_b mode%0d cyc=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    bit pat [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    load_bank(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = pat[i];
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL stall mode%0d cyc=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      if (i >= 2 && i <= 4) begin
        n_vec++;
        if (r_step !== 3'd2 || r_valid !== 1'b0 || c_valid !== 1'b0) begin
          n_err++; $display("FAIL stall_hold step=%0d valid=%b want step=2 valid=0", r_step, r_valid);
        end
      end
      step();
    end
    en = 1'b1;
    n_vec++;
    if (r_done !== 1'b1 || c_done !== 1'b1) begin
      n_err++; $display("FAIL stall_done got=%b/%b want=1 after 7 enabled cycles", r_done, c_done);
    end
    step();
  endtask

  task automatic test_illegal();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if (r_busy !== 1'b0 || c_busy !== 1'b0) begin
      n_err++; $display("FAIL empty_start busy=%b/%b want=0", r_busy, c_busy);
    end
    load_bank(1'b0);
    load_bank(1'b0);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_row = 2'(i);
      for (int c = 0; c < DIM; c++) wr_data[c] = 8'($urandom);
      wr_commit = 1'b1;
      step();
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    n_vec++;
    if (r_full !== 2'b11 || r_ready !== 1'b0) begin
      n_err++; $display("FAIL illegal_flags full=%b ready=%b want 11 0", r_full, r_ready);
    end
    for (int s = 0; s < 2; s++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        #1;
        for (int m = 0; m < 2; m++) begin
          n_vec++;
          if (act_obs(m) !== exp_obs(m)) begin
            n_err++; $display("FAIL illegal_stream%0d mode%0d cyc=%0d got=%h want=%h", s, m, i, act_obs(m), exp_obs(m));
          end
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    load_bank(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_vec++;
    if (r_busy !== 1'b0 || r_done !== 1'b0 || r_full !== 2'b00 || r_data !== 32'h0 || c_data !== 32'h0) begin
      n_err++; $display("FAIL reset_mid busy=%b done=%b full=%b data=%h want 0 0 00 0", r_busy, r_done, r_full, r_data);
    end
    load_bank(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL reset_mid_restream mode%0d cyc=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      if (i == 3) begin
        n_vec++;
        if (r_data !== 32'h1E150C03 || c_data !== 32'h030C151E) begin
          n_err++; $display("FAIL reset_mid_literal got=%h/%h want=1e150c03/030c151e", r_data, c_data);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      wr_en     = $urandom_range(0, 1) != 0;
      wr_row    = 2'($urandom_range(0, 3));
      for (int c = 0; c < DIM; c++) wr_data[c] = 8'($urandom);
      wr_commit = ($urandom_range(0, 5) == 0);
      start     = ($urandom_range(0, 3) == 0);
      en        = ($urandom_range(0, 3) != 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (act_obs(m) !== exp_obs(m)) begin
          n_err++; $display("FAIL random mode%0d cyc=%0d got=%h want=%h", m, i, act_obs(m), exp_obs(m));
        end
      end
      step();
    end
    rst = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; start = 1'b0;
  endtask

  initial begin
    m_full = '0; m_wr = 0; m_rd = 0; m_t = 0; m_stream = 0; m_done = 0;
    test_reset();
    test_single_stream();
    test_pingpong();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
